// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath blocks.
//   state_t      : sequencer state encoding (IDLE / RUN / DONE)
//   N_DEFAULT    : default dividend / quotient width
//   M_DEFAULT    : default divisor / remainder width
package calc_pkg;

  localparam int unsigned N_DEFAULT = 8;
  localparam int unsigned M_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   r       (in,  M+1) current partial remainder
//   bit_in  (in,  1)   next dividend bit shifted in
//   divisor (in,  M)   divisor
//   r_next  (out, M+1) partial remainder after the step
//   q_bit   (out, 1)   quotient bit produced by the step
module div_step #(
  parameter int unsigned M = 4
) (
  input  logic [M:0]   r,
  input  logic         bit_in,
  input  logic [M-1:0] divisor,
  output logic [M:0]   r_next,
  output logic         q_bit
);

  // Trial value carries the full partial remainder; its top bits stay zero
  // because the remainder is always below the divisor, so this matches the
  // {r[M-1:0], bit_in} form while keeping every bit of r in the compare.
  logic [M+1:0] t;

  always_comb begin
    t      = {r, bit_in};
    q_bit  = (t >= {2'b00, divisor});
    r_next = q_bit ? (M+1)'(t - {2'b00, divisor}) : t[M:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock.
// Ports:
//   clk         (in)     system clock, rising edge
//   rst_n       (in)     synchronous active-low reset
//   start       (in)     request, accepted in IDLE or DONE
//   dividend    (in,  N) captured on accepted start
//   divisor     (in,  M) captured on accepted start
//   busy        (out)    high while an operation is running
//   done        (out)    one-cycle pulse when results become valid
//   quotient    (out, N) result, held until next completion
//   remainder   (out, M) result, held until next completion
//   div_by_zero (out)    set with results when divisor was zero
module seq_divider
  import calc_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned M = M_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state, state_next;

  logic [N-1:0]  q_reg;
  logic [M:0]    r_reg;
  logic [M-1:0]  dvsr;
  logic [CW-1:0] count;

  logic          accept;
  logic          last_step;
  logic [M:0]    r_next;
  logic          q_bit;

  div_step #(.M(M)) u_step (
    .r       (r_reg),
    .bit_in  (q_reg[N-1]),
    .divisor (dvsr),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? ST_DONE : ST_RUN;
        end else if (state == ST_DONE) begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (count == LAST) begin
          last_step  = 1'b1;
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // done is registered from the DONE state, so it appears one clock after
  // the state is entered and never combinationally from the inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg       <= '0;
      r_reg       <= '0;
      dvsr        <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_next == ST_RUN);
      done <= (state == ST_DONE);
      if (accept) begin
        if (divisor != '0) begin
          q_reg <= dividend;
          r_reg <= '0;
          dvsr  <= divisor;
          count <= '0;
        end else begin
          quotient    <= '1;
          remainder   <= '0;
          div_by_zero <= 1'b1;
        end
      end else if (state == ST_RUN) begin
        q_reg <= {q_reg[N-2:0], q_bit};
        r_reg <= r_next;
        count <= count + CW'(1);
        if (last_step) begin
          quotient    <= {q_reg[N-2:0], q_bit};
          remainder   <= r_next[M-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring divider; the inverse of the calculator's multiply path.
- Takes an N-bit dividend (for example an 8-bit product) and an M-bit divisor; returns quotient and remainder.
- Produces one quotient bit per clock.
- Sits beside the calculator datapath; operands are captured through a start/busy/done handshake.

Parameters:
- N, 8, dividend and quotient width
- M, 4, divisor and remainder width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request; sampled on rising edge
- dividend  input  N  captured on accepted start
- divisor  input  M  captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results become valid
- quotient  output  N  result; held until next accepted start
- remainder  output  M  result; held until next accepted start
- div_by_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- Reset: rst_n low at a rising edge gives state=IDLE and busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Reset applies in any state; an operation in progress is abandoned with no done pulse.
- States: IDLE, RUN, DONE (2-bit encoding).
- Start acceptance:
  - start is accepted only in IDLE or DONE; start in RUN is ignored, with no queueing.
- IDLE:
  - start=1 and divisor!=0: load dividend into shift register Q, load partial remainder R (M+1 bits) with 0, count=0, go to RUN, busy=1.
  - start=1 and divisor==0: go to DONE; quotient={N{1}}, remainder=0, div_by_zero=1.
- RUN: each edge performs one restoring step.
  - Form T = {R[M-1:0], Q[N-1]} (M+1 bits); shift Q left.
  - If T >= {1'b0, divisor}: R = T - divisor and Q[0]=1. Otherwise R = T and Q[0]=0.
  - count increments each step.
  - On the step with count==N-1, the final values go to quotient/remainder, div_by_zero=0, state goes to DONE, busy=0.
- DONE: done=1 for exactly this one cycle, then IDLE.
  - start in DONE is accepted: back-to-back operation, same loading as in IDLE.
  - done still pulses that cycle and output registers are overwritten only at completion of the new operation.
- Latency, nonzero divisor:
  - Start sampled at edge E, RUN covers edges E+1..E+N, done is high in the cycle after edge E+N+1.
  - That is N+1 clocks from the sampling edge; busy is high for N cycles.
- Latency, zero divisor: done is high in the cycle after edge E+1 (1 clock).
- Width rules and invariants:
  - R is kept M+1 bits so the compare never overflows.
  - Remainder < divisor always.
  - quotient*divisor + remainder == dividend for every nonzero divisor.
- Operands are captured at acceptance; input changes during RUN have no effect.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (calc_pkg): state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; default widths N=8, M=4.
- One natural sub-module: div_step, combinational.
  - Inputs: R, next dividend bit, divisor.
  - Outputs: next R and quotient bit.
  - Instantiated once and reused each cycle.
- Counter and FSM stay in seq_divider.

Test Plan:
- Reset mid-run: start 143/7, assert rst_n=0 at cycle 4 -> next cycle busy=0, done=0, quotient=0, remainder=0; no done pulse follows.
- Basic divide: dividend=8'd143, divisor=4'd7, start 1 cycle -> busy high 8 cycles; done 9 clocks after the sampling edge; quotient=8'd20, remainder=4'd3, div_by_zero=0.
- Extremes:
  - 255/1 -> quotient=8'd255, remainder=0.
  - 255/15 -> quotient=8'd17, remainder=0.
  - 0/9 -> quotient=0, remainder=0.
  - 5/13 -> quotient=0, remainder=4'd5.
- Divide by zero: 100/0 -> done 1 clock after start; quotient=8'hFF, remainder=0, div_by_zero=1. A following 200/13 clears the flag and gives quotient=8'd15, remainder=4'd5.
- Handshake:
  - start held high and operands changed during RUN -> ignored; results reflect the captured operands.
  - start asserted in the DONE cycle -> second operation accepted, with back-to-back done pulses N+1 clocks apart.
- Randomized self-check: 1000 random operand pairs with nonzero divisor -> quotient*divisor+remainder==dividend and remainder<divisor.
